// File: rtl/alu_result_checker.sv
// alu_result_checker: receive end of the ALU test-vector path.
// Accepts expected results, samples the ALU after a settle delay, keeps stats.
module alu_result_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_VECTORS   = 15,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             VecValid,
    output logic             VecReady,
    input  logic [15:0]      ExpC,
    input  logic [5:0]       ExpFlags,
    input  logic [5:0]       FlagMask,
    input  logic [15:0]      C,
    input  logic [5:0]       Flags,
    output logic [CNT_W-1:0] VecIdx,
    output logic             ResultValid,
    output logic             ResultPass,
    output logic [CNT_W-1:0] PassCount,
    output logic [CNT_W-1:0] FailCount,
    output logic             AnyFail,
    output logic [CNT_W-1:0] FirstFailIdx,
    output logic [15:0]      FirstFailC,
    output logic [5:0]       FirstFailFlags,
    output logic             Done
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] COMPARE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [15:0]      exp_c_q, exp_c_d;
    logic [5:0]       exp_f_q, exp_f_d;
    logic [5:0]       mask_q, mask_d;
    logic [15:0]      cap_c_q, cap_c_d;
    logic [5:0]       cap_f_q, cap_f_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             rv_q, rv_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             any_q, any_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [15:0]      ff_c_q, ff_c_d;
    logic [5:0]       ff_f_q, ff_f_d;
    logic             match;

    assign match = (cap_c_q == exp_c_q) &&
                   (((cap_f_q ^ exp_f_q) & mask_q) == 6'd0);

    // Next-state: handshake, settle countdown, sample, compare and statistics
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        exp_c_d  = exp_c_q;
        exp_f_d  = exp_f_q;
        mask_d   = mask_q;
        cap_c_d  = cap_c_q;
        cap_f_d  = cap_f_q;
        idx_d    = idx_q;
        rv_d     = 1'b0;
        pass_d   = pass_q;
        pcnt_d   = pcnt_q;
        fcnt_d   = fcnt_q;
        any_d    = any_q;
        ff_idx_d = ff_idx_q;
        ff_c_d   = ff_c_q;
        ff_f_d   = ff_f_q;
        unique case (state_q)
            IDLE: begin
                if (VecValid) begin
                    exp_c_d = ExpC;
                    exp_f_d = ExpFlags;
                    mask_d  = FlagMask;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SW'(1);
                end else begin
                    cap_c_d = C;
                    cap_f_d = Flags;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                rv_d   = 1'b1;
                pass_d = match;
                if (match) begin
                    if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_W'(1);
                end else begin
                    if (fcnt_q != CNT_MAX) fcnt_d = fcnt_q + CNT_W'(1);
                    if (!any_q) begin
                        ff_idx_d = idx_q;
                        ff_c_d   = cap_c_q;
                        ff_f_d   = cap_f_q;
                        any_d    = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            exp_c_q  <= '0;
            exp_f_q  <= '0;
            mask_q   <= '0;
            cap_c_q  <= '0;
            cap_f_q  <= '0;
            idx_q    <= '0;
            rv_q     <= 1'b0;
            pass_q   <= 1'b0;
            pcnt_q   <= '0;
            fcnt_q   <= '0;
            any_q    <= 1'b0;
            ff_idx_q <= '0;
            ff_c_q   <= '0;
            ff_f_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            exp_c_q  <= exp_c_d;
            exp_f_q  <= exp_f_d;
            mask_q   <= mask_d;
            cap_c_q  <= cap_c_d;
            cap_f_q  <= cap_f_d;
            idx_q    <= idx_d;
            rv_q     <= rv_d;
            pass_q   <= pass_d;
            pcnt_q   <= pcnt_d;
            fcnt_q   <= fcnt_d;
            any_q    <= any_d;
            ff_idx_q <= ff_idx_d;
            ff_c_q   <= ff_c_d;
            ff_f_q   <= ff_f_d;
        end
    end

    assign VecReady       = (state_q == IDLE);
    assign Done           = (state_q == DONE);
    assign VecIdx         = idx_q;
    assign ResultValid    = rv_q;
    assign ResultPass     = pass_q;
    assign PassCount      = pcnt_q;
    assign FailCount      = fcnt_q;
    assign AnyFail        = any_q;
    assign FirstFailIdx   = ff_idx_q;
    assign FirstFailC     = ff_c_q;
    assign FirstFailFlags = ff_f_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed vectors with hand-computed expectations
// for the ALU result checker.
module tb_alu_result_checker;

    localparam int S  = 2;
    localparam int NV = 15;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          VecValid = 1'b0;
    logic          VecReady;
    logic [15:0]   ExpC = '0;
    logic [5:0]    ExpFlags = '0;
    logic [5:0]    FlagMask = '0;
    logic [15:0]   C = '0;
    logic [5:0]    Flags = '0;
    logic [CW-1:0] VecIdx;
    logic          ResultValid;
    logic          ResultPass;
    logic [CW-1:0] PassCount;
    logic [CW-1:0] FailCount;
    logic          AnyFail;
    logic [CW-1:0] FirstFailIdx;
    logic [15:0]   FirstFailC;
    logic [5:0]    FirstFailFlags;
    logic          Done;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_checker #(
        .SETTLE_CYCLES(S),
        .NUM_VECTORS  (NV),
        .CNT_W        (CW)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .VecValid      (VecValid),
        .VecReady      (VecReady),
        .ExpC          (ExpC),
        .ExpFlags      (ExpFlags),
        .FlagMask      (FlagMask),
        .C             (C),
        .Flags         (Flags),
        .VecIdx        (VecIdx),
        .ResultValid   (ResultValid),
        .ResultPass    (ResultPass),
        .PassCount     (PassCount),
        .FailCount     (FailCount),
        .AnyFail       (AnyFail),
        .FirstFailIdx  (FirstFailIdx),
        .FirstFailC    (FirstFailC),
        .FirstFailFlags(FirstFailFlags),
        .Done          (Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reset for two edges with random inputs and VecValid forced high
    task automatic do_reset();
        @(negedge CLK);
        RESET    = 1'b1;
        VecValid = 1'b1;
        ExpC     = 16'($urandom);
        ExpFlags = 6'($urandom);
        FlagMask = 6'($urandom);
        C        = 16'($urandom);
        Flags    = 6'($urandom);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET    = 1'b0;
        VecValid = 1'b0;
    endtask

    // Drive one vector; C is c_early until the edge before the sample,
    // c/f at the sample edge, zero afterwards. Returns 1 after E(S+1).
    task automatic run_vec(input logic [15:0] ec, input logic [5:0] ef,
                           input logic [5:0] fm, input logic [15:0] c_early,
                           input logic [15:0] c, input logic [5:0] f);
        int n;
        n = 0;
        @(negedge CLK);
        while (!VecReady && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!VecReady) chk("ready_wait", 32'(VecReady), 1);
        ExpC     = ec;
        ExpFlags = ef;
        FlagMask = fm;
        C        = c_early;
        Flags    = f;
        VecValid = 1'b1;
        @(posedge CLK);
        #1;
        VecValid = 1'b0;
        ExpC     = ~ec;
        ExpFlags = ~ef;
        FlagMask = ~fm;
        chk("settle_ready", 32'(VecReady), 0);
        repeat (S - 1) @(posedge CLK);
        #1;
        C = c;
        @(posedge CLK);
        #1;
        C     = 16'h0000;
        Flags = 6'h00;
        @(posedge CLK);
        #1;
        chk("result_valid", 32'(ResultValid), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_rv;
        logic [15:0] cv;

        // Reset state
        do_reset();
        chk("rst_ready", 32'(VecReady), 1);
        chk("rst_idx", 32'(VecIdx), 0);
        chk("rst_rv", 32'(ResultValid), 0);
        chk("rst_pass", 32'(ResultPass), 0);
        chk("rst_pcnt", 32'(PassCount), 0);
        chk("rst_fcnt", 32'(FailCount), 0);
        chk("rst_any", 32'(AnyFail), 0);
        chk("rst_ffidx", 32'(FirstFailIdx), 0);
        chk("rst_ffc", 32'(FirstFailC), 0);
        chk("rst_fff", 32'(FirstFailFlags), 0);
        chk("rst_done", 32'(Done), 0);

        // Single pass
        run_vec(16'h0008, 6'h00, 6'h3F, 16'h0008, 16'h0008, 6'h00);
        chk("sp_pass", 32'(ResultPass), 1);
        chk("sp_pcnt", 32'(PassCount), 1);
        chk("sp_fcnt", 32'(FailCount), 0);
        chk("sp_idx", 32'(VecIdx), 1);
        chk("sp_ready", 32'(VecReady), 1);
        @(posedge CLK);
        #1;
        chk("sp_rv_pulse", 32'(ResultValid), 0);
        chk("sp_pass_hold", 32'(ResultPass), 1);

        // Flag masking
        do_reset();
        run_vec(16'h0000, 6'h00, 6'b111110, 16'h0000, 16'h0000, 6'b000001);
        chk("fm_pass0", 32'(ResultPass), 1);
        chk("fm_any0", 32'(AnyFail), 0);
        run_vec(16'h0000, 6'h00, 6'h3F, 16'h0000, 16'h0000, 6'b000001);
        chk("fm_pass1", 32'(ResultPass), 0);
        chk("fm_fcnt", 32'(FailCount), 1);
        chk("fm_pcnt", 32'(PassCount), 1);
        chk("fm_ffidx", 32'(FirstFailIdx), 1);
        chk("fm_fff", 32'(FirstFailFlags), 32'h01);
        chk("fm_ffc", 32'(FirstFailC), 0);
        chk("fm_any", 32'(AnyFail), 1);

        // Sample point: only the value at the sample edge matters
        run_vec(16'h0006, 6'h00, 6'h3F, 16'h0005, 16'h0006, 6'h00);
        chk("spt_pass", 32'(ResultPass), 1);
        chk("spt_pcnt", 32'(PassCount), 2);
        chk("spt_ffidx", 32'(FirstFailIdx), 1);

        // Full run of NV vectors, wrong C on 3 and 7
        do_reset();
        for (int i = 0; i < NV; i++) begin
            cv = (i == 3 || i == 7) ? 16'hFFFF : 16'(i);
            run_vec(16'(i), 6'(i), 6'h3F, cv, cv, 6'(i));
            chk($sformatf("fr_pass%0d", i), 32'(ResultPass),
                (i == 3 || i == 7) ? 0 : 1);
            chk($sformatf("fr_done%0d", i), 32'(Done), (i == NV - 1) ? 1 : 0);
            chk($sformatf("fr_idx%0d", i), 32'(VecIdx),
                (i == NV - 1) ? NV - 1 : i + 1);
        end
        chk("fr_pcnt", 32'(PassCount), 13);
        chk("fr_fcnt", 32'(FailCount), 2);
        chk("fr_ffidx", 32'(FirstFailIdx), 3);
        chk("fr_ffc", 32'(FirstFailC), 32'hFFFF);
        chk("fr_fff", 32'(FirstFailFlags), 3);
        chk("fr_any", 32'(AnyFail), 1);
        chk("fr_ready", 32'(VecReady), 0);

        // Done holds against further VecValid
        seen_rv = 1'b0;
        @(negedge CLK);
        VecValid = 1'b1;
        ExpC     = 16'h1234;
        C        = 16'h4321;
        repeat (10) begin
            @(negedge CLK);
            if (ResultValid) seen_rv = 1'b1;
        end
        VecValid = 1'b0;
        chk("dn_no_rv", 32'(seen_rv), 0);
        chk("dn_ready", 32'(VecReady), 0);
        chk("dn_done", 32'(Done), 1);
        chk("dn_pcnt", 32'(PassCount), 13);
        chk("dn_fcnt", 32'(FailCount), 2);
        chk("dn_idx", 32'(VecIdx), NV - 1);

        // Reset one cycle after accepting a failing vector
        do_reset();
        @(negedge CLK);
        ExpC     = 16'h0001;
        ExpFlags = 6'h00;
        FlagMask = 6'h3F;
        C        = 16'h0002;
        Flags    = 6'h00;
        VecValid = 1'b1;
        @(posedge CLK);
        #1;
        VecValid = 1'b0;
        RESET    = 1'b1;
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        seen_rv = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (ResultValid) seen_rv = 1'b1;
        end
        chk("rm_no_rv", 32'(seen_rv), 0);
        chk("rm_fcnt", 32'(FailCount), 0);
        chk("rm_idx", 32'(VecIdx), 0);
        chk("rm_ready", 32'(VecReady), 1);
        chk("rm_any", 32'(AnyFail), 0);
        run_vec(16'h0010, 6'h00, 6'h3F, 16'h0011, 16'h0011, 6'h00);
        chk("rm_pass", 32'(ResultPass), 0);
        chk("rm_fcnt2", 32'(FailCount), 1);
        chk("rm_ffidx", 32'(FirstFailIdx), 0);
        chk("rm_ffc", 32'(FirstFailC), 32'h0011);
        chk("rm_idx2", 32'(VecIdx), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
